mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
Load/store unit directly downstream of the pipeline's memory stage. It takes the mem-stage request (address, store data, size, extension) and performs byte-lane alignment. It issues one transaction on a word-addressed valid/ready data bus and returns an aligned, extended readout with a one-cycle ack. The pipeline holds its exec->mem registers until the ack arrives. Misaligned and illegal-size accesses, and bus timeouts, complete with an error and no data.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed from bus acceptance to response before an error completion; 0 disables the timeout.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-low reset
i_req  in  1  access request from mem stage, level, held until o_memory_ack
i_we  in  1  1 = store, 0 = load
i_mask_type  in  2  00 byte, 01 half, 10 word, 11 illegal
i_ext_type  in  1  load extension: 0 sign, 1 zero
i_memory_address  in  32  byte address
i_memory_data  in  32  store data, LSB-justified
o_memory_readout  out  32  aligned/extended load data
o_memory_ack  out  1  one-cycle completion pulse
o_memory_err  out  1  error flag, valid only with ack
o_bus_valid  out  1  bus request valid
o_bus_we  out  1  bus write
o_bus_addr  out  30  word address (byte address [31:2])
o_bus_wdata  out  32  lane-replicated write data
o_bus_be  out  4  byte enables
i_bus_ready  in  1  bus accepts request when valid&ready
i_bus_rdata  in  32  read word
i_bus_rvalid  in  1  response pulse, for both reads and writes

Behaviour:
- Reset (i_rst=0, asynchronous): state IDLE. All outputs are 0 and the timeout counter is cleared. Reset mid-transaction abandons it; o_bus_valid drops immediately.
- States: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE:
  - On i_req=1, the request fields are captured into internal registers.
  - Legal and aligned -> ISSUE.
  - Misaligned -> DONE with err=1, and no bus activity. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal size (mask_type=11) -> DONE with err=1, and no bus activity.
- ISSUE:
  - o_bus_valid=1; all bus fields are driven from the captured registers and held stable until accepted.
  - valid&ready -> WAIT_RSP, counter cleared.
  - The timeout does not run in ISSUE.
- WAIT_RSP:
  - i_bus_rvalid -> DONE. For a load, the read word is registered into o_memory_readout.
  - Counter increments each cycle. When it reaches TIMEOUT_CYCLES without rvalid (and TIMEOUT_CYCLES≠0) -> DONE with err=1.
  - rvalid arriving in the same cycle the counter expires wins: normal completion.
- DONE:
  - o_memory_ack=1 for exactly one cycle; o_memory_err as determined.
  - Next state is IDLE. A new request is not accepted in DONE.
  - After the ack, i_req sampled in IDLE is treated as a new access.
- rvalid received outside WAIT_RSP (for example a late response after a timeout) is ignored.
- Store lane mapping, where a = addr[1:0]:
  - Byte: wdata = {4{data[7:0]}}, be = 0001<<a.
  - Half: wdata = {2{data[15:0]}}, be = a[1] ? 1100 : 0011.
  - Word: wdata = data, be = 1111.
- Loads drive be per size as well; o_bus_wdata is don't-care for loads.
- Load extraction:
  - Byte = rdata[8a+7:8a]; half = rdata[16a[1]+15:16a[1]].
  - Extended to 32 bits by i_ext_type; word is passed through unchanged.
- o_memory_readout:
  - Updated only on a successful load completion.
  - Set to 0 on any error completion.
  - Unchanged on a store completion.
  - Held between completions.
- Latency (load, zero-wait bus): req sampled cycle 0, valid cycle 1 with ready in cycle 1, rvalid cycle 2, ack+data cycle 3. Error completions: ack in cycle 1.
- If i_req drops while a transaction is in flight, the transaction still completes and acks.

Test Plan:
- Aligned LW @0x100, bus returns 0xDEADBEEF with ready held 1 -> o_bus_addr=0x40, be=1111, valid cycle 1, ack cycle 3, readout=0xDEADBEEF, err=0.
- LB @0x103 sign-extend, rdata=0x80112233 -> be=1000, readout=0xFFFFFF80. Repeat with ext=1 -> readout=0x00000080.
- SH @0x206 data=0x0000ABCD with ready delayed 4 cycles -> valid held with stable fields for 5 cycles, wdata=0xABCDABCD, be=1100. Ack 1 cycle after rvalid, readout unchanged.
- LW @0x102, and separately mask_type=11 -> no o_bus_valid, ack+err in cycle 1, readout=0.
- TIMEOUT_CYCLES=4, request accepted with no rvalid -> ack+err exactly 4 cycles after acceptance. Later rvalid is ignored, and the next request completes normally.
- Assert i_rst=0 during WAIT_RSP -> outputs zero asynchronously. After release, a fresh LW completes with the 3-cycle latency and no stale ack.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Load/store unit behind the pipeline memory stage.
// Accepts one request at a time and places the byte lanes for it.
// It runs a single transaction on a word-addressed valid/ready bus and then
// acknowledges with a one-cycle pulse. Loads return aligned, extended data.
// Misaligned accesses, illegal sizes and bus timeouts complete with an error.
//
// Bus handshake: a request is transferred in the cycle where o_bus_valid and
// i_bus_ready are both high. While o_bus_valid waits for i_bus_ready, every
// bus field holds stable. After the transfer, one i_bus_rvalid pulse returns
// the response, for writes as well as reads. An rvalid that arrives in any
// state other than WAIT_RSP is dropped.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_mask_type,
    input  logic        i_ext_type,
    input  logic [31:0] i_memory_address,
    input  logic [31:0] i_memory_data,
    output logic [31:0] o_memory_readout,
    output logic        o_memory_ack,
    output logic        o_memory_err,
    output logic        o_bus_valid,
    output logic        o_bus_we,
    output logic [29:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_rvalid,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        mask_q;
    logic              ext_q;
    logic [1:0]        off_q;
    logic              bus_valid_q;
    logic              bus_we_q;
    logic [29:0]       bus_addr_q;
    logic [31:0]       bus_wdata_q;
    logic [3:0]        bus_be_q;
    logic              ack_q;
    logic              err_q;
    logic [31:0]       readout_q;

    logic [1:0]        req_off;
    logic              req_bad;
    logic [31:0]       wdata_d;
    logic [3:0]        be_d;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              timeout_hit;

    // Decode the incoming request: legality and byte-lane placement of store data.
    always_comb begin
        req_off = i_memory_address[1:0];
        req_bad = (i_mask_type == 2'b11)
               || ((i_mask_type == 2'b01) && req_off[0])
               || ((i_mask_type == 2'b10) && (req_off != 2'b00));
        wdata_d = i_memory_data;
        be_d    = 4'b0000;
        case (i_mask_type)
            2'b00: begin
                wdata_d = {4{i_memory_data[7:0]}};
                be_d    = 4'b0001 << req_off;
            end
            2'b01: begin
                wdata_d = {2{i_memory_data[15:0]}};
                be_d    = req_off[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                wdata_d = i_memory_data;
                be_d    = 4'b1111;
            end
            default: begin
                wdata_d = i_memory_data;
                be_d    = 4'b0000;
            end
        endcase
    end

    // Extract and extend load data from the read word using the captured request.
    always_comb begin
        rd_byte = i_bus_rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (mask_q)
            2'b00:   load_d = ext_q ? {24'h000000, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_d = ext_q ? {16'h0000, rd_half}   : {{16{rd_half[15]}}, rd_half};
            default: load_d = i_bus_rdata;
        endcase
    end

    // Response timeout: the next count value expires once it reaches the limit.
    // A zero limit turns the timeout off.
    always_comb begin
        cnt_d       = cnt_q + CNT_ONE;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_d == CNT_LIMIT);
    end

    // Transaction FSM. Every output is registered here.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mask_q      <= 2'b00;
            ext_q       <= 1'b0;
            off_q       <= 2'b00;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 30'h0;
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'h0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            readout_q   <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (i_req) begin
                        mask_q      <= i_mask_type;
                        ext_q       <= i_ext_type;
                        off_q       <= req_off;
                        bus_we_q    <= i_we;
                        bus_addr_q  <= i_memory_address[31:2];
                        bus_wdata_q <= wdata_d;
                        bus_be_q    <= be_d;
                        if (req_bad) begin
                            state_q   <= S_DONE;
                            ack_q     <= 1'b1;
                            err_q     <= 1'b1;
                            readout_q <= 32'h0;
                        end else begin
                            state_q     <= S_ISSUE;
                            bus_valid_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_bus_ready) begin
                        bus_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (i_bus_rvalid) begin
                        state_q <= S_DONE;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b0;
                        if (!bus_we_q) begin
                            readout_q <= load_d;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= S_DONE;
                        ack_q     <= 1'b1;
                        err_q     <= 1'b1;
                        readout_q <= 32'h0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_memory_readout = readout_q;
    assign o_memory_ack     = ack_q;
    assign o_memory_err     = err_q;
    assign o_bus_valid      = bus_valid_q;
    assign o_bus_we         = bus_we_q;
    assign o_bus_addr       = bus_addr_q;
    assign o_bus_wdata      = bus_wdata_q;
    assign o_bus_be         = bus_be_q;
    assign o_dbg_state      = state_q;

endmodule
